// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM that steps a datapath through MOV/MVN/ADD/CMP/AND.
// Moore outputs only; the instruction is held in IR from the accepting edge to completion.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] instr,
    input  logic [2:0]  status,
    output logic        w,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [15:0] sximm8,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        illegal
);
    typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WB} state_t;
    state_t state, state_nxt;
    logic [15:0] ir;
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic is_movi, is_movr, is_mvn, is_alu, is_cmp, legal;
    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign is_movi = opcode == 3'b110 && op == 2'b10;
    assign is_movr = opcode == 3'b110 && op == 2'b00;
    assign is_mvn  = opcode == 3'b101 && op == 2'b11;
    assign is_alu  = opcode == 3'b101 && op != 2'b11;
    assign is_cmp  = opcode == 3'b101 && op == 2'b01;
    assign legal   = is_movi || is_movr || is_mvn || is_alu;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= WAIT;
            ir      <= '0;
            N       <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == WAIT && s) begin
                ir      <= instr;
                illegal <= 1'b0;
            end
            if (state == DECODE && !legal)
                illegal <= 1'b1;
            if (loads)
                {N, V, Z} <= status;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:      state_nxt = s ? DECODE : WAIT;
            DECODE:    state_nxt = is_movi ? WRITE_IMM : (is_movr || is_mvn) ? GET_B : is_alu ? GET_A : WAIT;
            WRITE_IMM: state_nxt = WAIT;
            GET_A:     state_nxt = GET_B;
            GET_B:     state_nxt = EXEC;
            EXEC:      state_nxt = is_cmp ? WAIT : WB;
            WB:        state_nxt = WAIT;
            default:   state_nxt = WAIT;
        endcase
    end
    assign w        = state == WAIT;
    assign ALUop    = opcode == 3'b101 ? op : 2'b00;
    assign shift    = state == GET_B ? sh : 2'b00;
    assign readnum  = state == GET_A ? rn : state == GET_B ? rm : 3'd0;
    assign writenum = state == WRITE_IMM ? rn : state == WB ? rd : 3'd0;
    assign write    = state == WRITE_IMM || state == WB;
    assign loada    = state == GET_A;
    assign loadb    = state == GET_B;
    assign loadc    = state == EXEC;
    assign loads    = state == EXEC && is_cmp;
    assign asel     = state == EXEC && (is_movr || is_mvn);
    assign bsel     = 1'b0;
    assign vsel     = state == WRITE_IMM ? 2'b10 : 2'b00;
    assign sximm8   = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed per-instruction scenarios with cycle-by-cycle expected strobe vectors.
module tb_alu_sequencer;
    logic clk = 0, reset = 1, s = 0;
    logic [15:0] instr = '0;
    logic [2:0] status = '0;
    logic w, write, loada, loadb, loadc, loads, asel, bsel, N, V, Z, illegal;
    logic [1:0] ALUop, shift, vsel;
    logic [2:0] readnum, writenum;
    logic [15:0] sximm8;
    logic [19:0] obs;
    int total = 0, bad = 0;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .instr(instr), .status(status),
        .w(w), .ALUop(ALUop), .shift(shift), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .sximm8(sximm8),
        .N(N), .V(V), .Z(Z), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign obs = {w, write, loada, loadb, loadc, loads, asel, bsel, readnum, writenum, vsel, shift, ALUop};

    function automatic logic [19:0] mk(input logic w_, wr, la, lb, lc, ls, as_,
                                       input logic [2:0] rn, wn, input logic [1:0] vs, sh, op);
        return {w_, wr, la, lb, lc, ls, as_, 1'b0, rn, wn, vs, sh, op};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        total++;
        if ({N, V, Z, illegal, sximm8} !== 20'h0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b%b%b sx=%h exp=0000 sx=0000", N, V, Z, illegal, sximm8);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_movi;
        logic [19:0] e [3];
        e = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 2'b10, 0, 0),
              mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        instr = 16'hD3FE;
        s = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            s = 0;
            instr = 16'h1234;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL movi cyc%0d got=%h exp=%h", i, obs, e[i]);
            end
        end
        total++;
        if (sximm8 !== 16'hFFFE) begin
            bad++;
            $display("FAIL movi_sximm8 got=%h exp=fffe", sximm8);
        end
    endtask

    task automatic test_add;
        logic [19:0] e [6];
        e = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0),
              mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0),
              mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        status = 3'b111;
        instr = 16'hA140;
        s = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            s = 0;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL add cyc%0d got=%h exp=%h", i, obs, e[i]);
            end
        end
        total++;
        if ({N, V, Z} !== 3'b000) begin
            bad++;
            $display("FAIL add_flags got=%b%b%b exp=000", N, V, Z);
        end
    endtask

    task automatic test_cmp;
        logic [19:0] e [5];
        e = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
              mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1),
              mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1),
              mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1),
              mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        status = 3'b001;
        instr = 16'hA900;
        s = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            s = 0;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL cmp cyc%0d got=%h exp=%h", i, obs, e[i]);
            end
        end
        status = 3'b110;
        total++;
        if ({N, V, Z} !== 3'b001) begin
            bad++;
            $display("FAIL cmp_flags got=%b%b%b exp=001", N, V, Z);
        end
    endtask

    task automatic test_illegal;
        instr = 16'hE000;
        s = 1;
        tick();
        s = 0;
        total++;
        if (w !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_decode got w=%b ill=%b exp w=0 ill=0", w, illegal);
        end
        tick();
        total++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0) || illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_done got=%h ill=%b exp=%h ill=1", obs, illegal, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        total++;
        if ({N, V, Z} !== 3'b001) begin
            bad++;
            $display("FAIL flags_hold got=%b%b%b exp=001", N, V, Z);
        end
        instr = 16'hD105;
        s = 1;
        tick();
        s = 0;
        total++;
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear got=%b exp=0", illegal);
        end
        tick();
        total++;
        if (obs !== mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0) || sximm8 !== 16'h0005) begin
            bad++;
            $display("FAIL movi2 got=%h sx=%h exp=%h sx=0005", obs, sximm8, mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
        end
        tick();
    endtask

    task automatic test_async_reset;
        instr = 16'hA140;
        s = 1;
        tick();
        s = 0;
        tick();
        tick();
        total++;
        if (loadb !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_getb got loadb=%b exp=1", loadb);
        end
        #2 reset = 1;
        #1;
        total++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0) || {N, V, Z, illegal} !== 4'b0) begin
            bad++;
            $display("FAIL async_reset got=%h nvzi=%b%b%b%b exp=%h nvzi=0000", obs, N, V, Z, illegal, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (write !== 1'b0 || w !== 1'b1) begin
                bad++;
                $display("FAIL post_reset cyc%0d got write=%b w=%b exp write=0 w=1", i, write, w);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] e [10];
        e = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3),
              mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3),
              mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3),
              mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3),
              mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3),
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk(0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 1, 0),
              mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0),
              mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0),
              mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        instr = 16'hB860;
        s = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) instr = 16'hC06D;
            if (i == 8) s = 0;
            total++;
            if (obs !== e[i]) begin
                bad++;
                $display("FAIL b2b cyc%0d got=%h exp=%h", i, obs, e[i]);
            end
        end
        tick();
        total++;
        if (w !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle got w=%b exp=1", w);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_movi();
        test_add();
        test_cmp();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
